// File: rtl/wb_mem_responder.sv
// Wishbone classic responder over a word-organised scratch memory with byte lanes,
// programmable wait states and a registered read port. Define WB_MEM_ERR_EN to add o_wb_err.
module wb_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_LSB    = 0,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall
`ifdef WB_MEM_ERR_EN
  ,
  output logic        o_wb_err
`endif
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [27:0] DEPTH_L   = 28'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               ack_q;
  logic               stall_q;
  logic [31:0]        rdata_q;
  logic               we_q;
  logic [3:0]         sel_q;
  logic [31:0]        data_q;
  logic [IDX_W-1:0]   midx_q;
  logic               inr_q;
`ifdef WB_MEM_ERR_EN
  logic               err_q;
`endif

  logic [31:0]        mem [0:DEPTH-1];

  logic [27:0]        bus_idx_s;
  logic               bus_inr_s;
  logic               req_s;
  logic               is_idle_s;
  logic               go_ack_s;
  logic               cur_we_s;
  logic [3:0]         cur_sel_s;
  logic [31:0]        cur_data_s;
  logic [IDX_W-1:0]   cur_midx_s;
  logic               cur_inr_s;
  logic               mem_wr_s;
  logic [31:0]        mem_rd_s;
  logic               unused_addr_s;

  // Region-select bits take no part in decoding
  assign unused_addr_s = ^i_wb_addr[31:28];

  // Decode the live request; with no wait states the ack edge is the acceptance edge,
  // so the access must use bus values rather than the latched copy
  always_comb begin
    bus_idx_s = i_wb_addr[27:0] >> ADDR_LSB;
    bus_inr_s = (bus_idx_s < DEPTH_L);
    req_s     = i_wb_cyc & i_wb_stb;
    is_idle_s = (state_q == ST_IDLE);
    if (is_idle_s) begin
      cur_we_s   = i_wb_we;
      cur_sel_s  = i_wb_sel;
      cur_data_s = i_wb_data;
      cur_midx_s = bus_idx_s[IDX_W-1:0];
      cur_inr_s  = bus_inr_s;
    end else begin
      cur_we_s   = we_q;
      cur_sel_s  = sel_q;
      cur_data_s = data_q;
      cur_midx_s = midx_q;
      cur_inr_s  = inr_q;
    end
    if (is_idle_s) begin
      go_ack_s = req_s & NO_WAIT;
    end else if (state_q == ST_WAIT) begin
      go_ack_s = i_wb_cyc & (cnt_q == 4'd0);
    end else begin
      go_ack_s = 1'b0;
    end
    mem_wr_s = go_ack_s & cur_we_s & cur_inr_s;
    mem_rd_s = mem[cur_midx_s];
  end

  // Byte-lane memory write; contents are not reset so the array maps onto RAM
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel_s[b]) begin
          mem[cur_midx_s][8*b +: 8] <= cur_data_s[8*b +: 8];
        end
      end
    end
  end

  // Bus FSM with registered ack/stall/read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      data_q  <= 32'h0;
      midx_q  <= '0;
      inr_q   <= 1'b0;
`ifdef WB_MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef WB_MEM_ERR_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            we_q    <= i_wb_we;
            sel_q   <= i_wb_sel;
            data_q  <= i_wb_data;
            midx_q  <= bus_idx_s[IDX_W-1:0];
            inr_q   <= bus_inr_s;
            stall_q <= 1'b1;
            if (NO_WAIT) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end else begin
            stall_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!i_wb_cyc) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd0) begin
            state_q <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACK: begin
          state_q <= ST_RECOVER;
        end
        ST_RECOVER: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
      endcase
      if (go_ack_s) begin
`ifdef WB_MEM_ERR_EN
        if (!cur_inr_s) begin
          err_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
          if (!cur_we_s) begin
            rdata_q <= mem_rd_s;
          end
        end
`else
        ack_q <= 1'b1;
        if (!cur_we_s) begin
          rdata_q <= cur_inr_s ? mem_rd_s : 32'h0;
        end
`endif
      end
    end
  end

  assign o_wb_data  = rdata_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_stall = stall_q;
`ifdef WB_MEM_ERR_EN
  assign o_wb_err   = err_q;
`endif

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: instance 0 (1 wait, DEPTH 64, word addr), instance 1
// (0 waits, byte addr); a timeline model predicts ack/err/stall/data every cycle.
module tb_wb_mem_responder;

  localparam int NI = 2;
  localparam int WS_A = 1, DEPTH_A = 64,   LSB_A = 0;
  localparam int WS_B = 0, DEPTH_B = 1024, LSB_B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc [NI];
  logic        stb [NI];
  logic        we  [NI];
  logic [3:0]  sel [NI];
  logic [31:0] adr [NI];
  logic [31:0] wdat[NI];
  logic [31:0] rdat[NI];
  logic        ack [NI];
  logic        stall[NI];
  logic        err [NI];

  int n_err = 0;
  int n_checks = 0;
  int ack_cnt [NI];

  always #5 clk = ~clk;

  wb_mem_responder #(.DEPTH(DEPTH_A), .ADDR_LSB(LSB_A), .WAIT_STATES(WS_A)) u_a (
    .clk(clk), .rst(rst_n), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_sel(sel[0]), .i_wb_addr(adr[0]), .i_wb_data(wdat[0]), .o_wb_data(rdat[0]),
    .o_wb_ack(ack[0]), .o_wb_stall(stall[0])
`ifdef WB_MEM_ERR_EN
    , .o_wb_err(err[0])
`endif
  );

  wb_mem_responder #(.DEPTH(DEPTH_B), .ADDR_LSB(LSB_B), .WAIT_STATES(WS_B)) u_b (
    .clk(clk), .rst(rst_n), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_sel(sel[1]), .i_wb_addr(adr[1]), .i_wb_data(wdat[1]), .o_wb_data(rdat[1]),
    .o_wb_ack(ack[1]), .o_wb_stall(stall[1])
`ifdef WB_MEM_ERR_EN
    , .o_wb_err(err[1])
`endif
  );

`ifndef WB_MEM_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  function automatic int ws_of(input int k);
    return (k == 0) ? WS_A : WS_B;
  endfunction
  function automatic int depth_of(input int k);
    return (k == 0) ? DEPTH_A : DEPTH_B;
  endfunction
  function automatic int lsb_of(input int k);
    return (k == 0) ? LSB_A : LSB_B;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %08h want %08h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    chk(nm, k, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- timeline model ----------------
  int          m_e;
  bit          m_busy [NI];
  int          m_acc  [NI];
  logic        m_ack  [NI];
  logic        m_err  [NI];
  logic        m_stall[NI];
  logic [31:0] m_data [NI];
  bit          r_we   [NI];
  logic [3:0]  r_sel  [NI];
  int unsigned r_idx  [NI];
  logic [31:0] r_wd   [NI];
  logic [31:0] mm     [NI][1024];

  task automatic m_reset();
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 1'b0; m_ack[k] = 1'b0; m_err[k] = 1'b0;
      m_stall[k] = 1'b0; m_data[k] = 32'h0; m_acc[k] = 0;
    end
  endtask

  task automatic m_complete(input int k);
    if (r_idx[k] >= depth_of(k)) begin
`ifdef WB_MEM_ERR_EN
      m_err[k] = 1'b1;
`else
      m_ack[k] = 1'b1;
      if (!r_we[k]) m_data[k] = 32'h0;
`endif
    end else begin
      m_ack[k] = 1'b1;
      if (r_we[k]) begin
        for (int b = 0; b < 4; b++)
          if (r_sel[k][b]) mm[k][r_idx[k]][8*b +: 8] = r_wd[k][8*b +: 8];
      end else begin
        m_data[k] = mm[k][r_idx[k]];
      end
    end
  endtask

  // Accept at edge T; waits end at edge T+ws (ack), busy until edge T+ws+2
  task automatic m_step(input int k);
    int ws;
    ws = ws_of(k);
    m_ack[k] = 1'b0;
    m_err[k] = 1'b0;
    if (m_busy[k]) begin
      if (m_e <= m_acc[k] + ws && !cyc[k]) begin
        m_busy[k] = 1'b0; m_stall[k] = 1'b0;
      end else if (m_e == m_acc[k] + ws) begin
        m_complete(k);
      end else if (m_e == m_acc[k] + ws + 2) begin
        m_busy[k] = 1'b0; m_stall[k] = 1'b0;
      end
    end else if (cyc[k] && stb[k]) begin
      m_acc[k]  = m_e;
      m_busy[k] = 1'b1;
      m_stall[k] = 1'b1;
      r_we[k]  = we[k];
      r_sel[k] = sel[k];
      r_wd[k]  = wdat[k];
      r_idx[k] = 32'(adr[k][27:0]) >> lsb_of(k);
      if (ws == 0) m_complete(k);
    end
  endtask

  initial begin
    m_e = 0;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        m_e++;
        for (int k = 0; k < NI; k++) m_step(k);
      end
    end
  end

  // Per-cycle compare of both instances against the model
  initial begin
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk1("ack", k, ack[k], m_ack[k]);
        chk1("err", k, err[k], m_err[k]);
        chk1("stall", k, stall[k], m_stall[k]);
        chk("rdata", k, rdat[k], m_data[k]);
        if (ack[k] === 1'b1) ack_cnt[k]++;
      end
    end
  end

  // One transfer; strobe stays up through the recovery cycle
  task automatic bus_xfer(input int k, input bit w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, output bit got_ack, output bit got_err,
                          output logic [31:0] rd);
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wdat[k] = d;
    got_ack = 1'b0; got_err = 1'b0; rd = 32'h0;
    for (int i = 0; i < 40 && !got_ack && !got_err; i++) begin
      @(negedge clk); #1;
      if (ack[k] === 1'b1) begin got_ack = 1'b1; rd = rdat[k]; end
      if (err[k] === 1'b1) got_err = 1'b1;
    end
    if (!got_ack && !got_err) begin
      n_checks++; n_err++;
      $display("FAIL xfer_timeout inst%0d: got no response want ack/err for addr %08h", k, a);
    end
    @(negedge clk);
    @(negedge clk);
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500000");
    $fatal(1);
  end

  initial begin
    bit ga, ge;
    logic [31:0] rd;
    int base;
    int ack_t[$];
    logic st[16];
    int nacks;

    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; adr[k] = 32'h0; wdat[k] = 32'h0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk1("rst_ack", k, ack[k], 1'b0);
      chk1("rst_stall", k, stall[k], 1'b0);
      chk("rst_data", k, rdat[k], 32'h0);
    end

    base = ack_cnt[0];
    for (int i = 0; i < 64; i++) bus_xfer(0, 1'b1, 4'hF, 32'(i), 32'(i), ga, ge, rd);
    repeat (2) @(negedge clk); #1;
    chk("wr64_acks", 0, 32'(ack_cnt[0] - base), 32'd64);

    bus_xfer(0, 1'b0, 4'hF, 32'd37, 32'h0, ga, ge, rd);
    chk1("rd37_ack", 0, ga, 1'b1);
    chk("rd37", 0, rd, 32'h25);
    repeat (3) @(negedge clk); #1;
    chk("rd37_hold", 0, rdat[0], 32'h25);

    bus_xfer(0, 1'b1, 4'hF, 32'd5, 32'hAABBCCDD, ga, ge, rd);
    bus_xfer(0, 1'b1, 4'b0101, 32'd5, 32'h11223344, ga, ge, rd);
    bus_xfer(0, 1'b0, 4'hF, 32'd5, 32'h0, ga, ge, rd);
    chk("lanes5", 0, rd, 32'hAA22CC44);

    base = ack_cnt[0];
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 32'd3; wdat[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (4) @(negedge clk); #1;
    chk("abort_noack", 0, 32'(ack_cnt[0] - base), 32'd0);
    bus_xfer(0, 1'b0, 4'hF, 32'd3, 32'h0, ga, ge, rd);
    chk("abort_rd3", 0, rd, 32'h3);

    base = ack_cnt[0];
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 32'd10; wdat[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    #2 rst_n = 1'b0;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk); #1;
    chk1("rstw_stall", 0, stall[0], 1'b0);
    chk("rstw_data", 0, rdat[0], 32'h0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk); #1;
    chk("rstw_noack", 0, 32'(ack_cnt[0] - base), 32'd0);
    bus_xfer(0, 1'b0, 4'hF, 32'd10, 32'h0, ga, ge, rd);
    chk("rstw_rd10", 0, rd, 32'hA);

    bus_xfer(0, 1'b1, 4'hF, 32'd20, 32'h12345678, ga, ge, rd);
    bus_xfer(0, 1'b0, 4'hF, 32'd20, 32'h0, ga, ge, rd);
    chk("raw20", 0, rd, 32'h12345678);
    bus_xfer(0, 1'b1, 4'h0, 32'd20, 32'hFFFF_FFFF, ga, ge, rd);
    chk1("sel0_ack", 0, ga, 1'b1);
    bus_xfer(0, 1'b0, 4'hF, 32'd20, 32'h0, ga, ge, rd);
    chk("sel0_rd20", 0, rd, 32'h12345678);

    bus_xfer(0, 1'b1, 4'hF, 32'd64, 32'h5A5A5A5A, ga, ge, rd);
`ifdef WB_MEM_ERR_EN
    chk1("oor_wr_err", 0, ge, 1'b1);
    chk1("oor_wr_ack", 0, ga, 1'b0);
    bus_xfer(0, 1'b0, 4'hF, 32'd64, 32'h0, ga, ge, rd);
    chk1("oor_rd_err", 0, ge, 1'b1);
    chk("oor_rd_data", 0, rdat[0], 32'h12345678);
`else
    chk1("oor_wr_ack", 0, ga, 1'b1);
    bus_xfer(0, 1'b0, 4'hF, 32'd64, 32'h0, ga, ge, rd);
    chk1("oor_rd_ack", 0, ga, 1'b1);
    chk("oor_rd_data", 0, rd, 32'h0);
`endif
    bus_xfer(0, 1'b0, 4'hF, 32'd0, 32'h0, ga, ge, rd);
    chk("oor_rd0", 0, rd, 32'h0);
    bus_xfer(0, 1'b0, 4'hF, 32'hF000_0025, 32'h0, ga, ge, rd);
    chk("region_rd", 0, rd, 32'h25);

    bus_xfer(1, 1'b1, 4'hF, 32'h10, 32'hCAFE_0004, ga, ge, rd);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      st[i] = stall[1];
      if (ack[1] === 1'b1) begin
        ack_t.push_back(i);
        chk("b2b_data", 1, rdat[1], 32'hCAFE_0004);
      end
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    nacks = ack_t.size();
    chk("b2b_nacks", 1, 32'(nacks), 32'd4);
    for (int j = 1; j < nacks; j++) chk("b2b_gap", 1, 32'(ack_t[j] - ack_t[j-1]), 32'd3);
    for (int j = 0; j < nacks; j++) begin
      if (ack_t[j] + 2 < 12) begin
        chk1("b2b_stall0", 1, st[ack_t[j]], 1'b1);
        chk1("b2b_stall1", 1, st[ack_t[j] + 1], 1'b1);
        chk1("b2b_stall2", 1, st[ack_t[j] + 2], 1'b0);
      end
    end
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
